// File: rtl/instr_queue_pkg.sv
// Shared types for the Tomasulo front end: the decoded control word handed
// from decode to dispatch, plus instruction-queue local constants.

package tomasula_types;

  typedef enum logic [2:0] {
    ARITH  = 3'd0,
    LUI    = 3'd1,
    AUIPC  = 3'd2,
    BRANCH = 3'd3,
    LD     = 3'd4,
    ST     = 3'd5,
    JALR   = 3'd6
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [4:0]  src1_reg;
    logic [31:0] src1_data;
    logic        src1_valid;
    logic [4:0]  src2_reg;
    logic [31:0] src2_data;
    logic        src2_valid;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] pc;
  } ctl_word;

endpackage

package instr_queue_pkg;

  import tomasula_types::*;

  localparam int IQ_DEPTH_DEFAULT = 8;
  localparam int CW_W             = $bits(ctl_word);

  // True when n is a power of two and at least 2 (legal queue depth).
  function automatic bit depth_ok(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/instr_queue_ptr.sv
// Wrapping queue pointer: clears on reset or flush, otherwise steps by one
// on inc. Width equals log2(DEPTH), so the natural overflow is the wrap.

module iq_ptr #(
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  // Pointer register; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || clr) ptr <= '0;
    else if (inc)   ptr <= ptr + PTR_W'(1);
  end

endmodule

// File: rtl/instr_queue.sv
// Circular instruction queue between decode and Tomasulo dispatch.
// Enqueue side uses ld_iq/ack_o, dequeue side uses dq_valid/dq_ready.
// flush empties the queue in one cycle (mispredict recovery); rst does the
// same and also zeroes storage so the head word reads as zero.

module instr_queue
  import tomasula_types::*;
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEFAULT,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_iq,
  input  ctl_word          control_word_i,
  output logic             ack_o,
  output logic             dq_valid,
  output ctl_word          control_word_o,
  input  logic             dq_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  ctl_word          mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic             push, pop;

  // Acceptance ignores dq_ready so decode never sees a path through dispatch;
  // a full queue refuses even if the head is popped this same cycle.
  assign ack_o    = ld_iq & ~full & ~flush;
  assign push     = ack_o;
  assign dq_valid = (count != '0);
  assign pop      = dq_valid & dq_ready & ~flush;
  assign full     = (count == CNT_W'(DEPTH));

  assign control_word_o = mem[head];

  iq_ptr #(.PTR_W(PTR_W)) u_head (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop),
    .ptr (head)
  );

  iq_ptr #(.PTR_W(PTR_W)) u_tail (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push),
    .ptr (tail)
  );

  // Storage write at tail; reset zeroes every entry, flush leaves them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[tail] <= control_word_i;
    end
  end

  // Occupancy: simultaneous push and pop cancel out.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Elaboration-time sanity on the depth parameter.
  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("instr_queue: DEPTH must be a power of two and >= 2");
  end

  a_count_range: assert property (@(posedge clk) disable iff (rst)
    count <= CNT_W'(DEPTH));
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
    !(pop && count == '0));
`endif

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue with a reference occupancy model and an
// in-order scoreboard of pushed control words.

module tb_instr_queue;
  import tomasula_types::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int W     = $bits(ctl_word);

  typedef logic [W-1:0] wv_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             ld_iq;
  ctl_word          cw_i;
  logic             ack_o;
  logic             dq_valid;
  ctl_word          cw_o;
  logic             dq_ready;
  logic             flush;
  logic [CNT_W-1:0] count;
  logic             full;

  int      checks = 0;
  int      errors = 0;
  int      mcount = 0;
  ctl_word sb [$];

  instr_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .ld_iq          (ld_iq),
    .control_word_i (cw_i),
    .ack_o          (ack_o),
    .dq_valid       (dq_valid),
    .control_word_o (cw_o),
    .dq_ready       (dq_ready),
    .flush          (flush),
    .count          (count),
    .full           (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input wv_t obs, input wv_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ctl_word mk(input logic [31:0] pc);
    ctl_word w;
    w.op         = op_t'($urandom_range(0, 6));
    w.src1_reg   = 5'($urandom);
    w.src1_data  = $urandom;
    w.src1_valid = 1'($urandom);
    w.src2_reg   = 5'($urandom);
    w.src2_data  = $urandom;
    w.src2_valid = 1'($urandom);
    w.funct3     = 3'($urandom);
    w.funct7     = 7'($urandom);
    w.rd         = 5'($urandom);
    w.pc         = pc;
    return w;
  endfunction

  // One clock cycle: drive, check combinational outputs against the model,
  // update scoreboard, then advance past the edge.
  task automatic cyc(input logic ld, input logic [31:0] pc,
                     input logic rdy, input logic fl);
    ctl_word w, e;
    logic    pe, po;
    w = mk(pc);
    ld_iq = ld; cw_i = w; dq_ready = rdy; flush = fl;
    #1;
    pe = ld && (mcount < DEPTH) && !fl;
    po = (mcount > 0) && rdy && !fl;
    chk("ack_o",    wv_t'(ack_o),    wv_t'(pe));
    chk("dq_valid", wv_t'(dq_valid), wv_t'(mcount != 0));
    chk("count",    wv_t'(count),    wv_t'(mcount));
    chk("full",     wv_t'(full),     wv_t'(mcount == DEPTH));
    if (po) begin
      e = sb.pop_front();
      chk("head_word", wv_t'(cw_o), wv_t'(e));
    end
    if (fl) begin
      sb.delete();
      mcount = 0;
    end else begin
      if (pe) sb.push_back(w);
      mcount = mcount + int'(pe) - int'(po);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    while (mcount > 0) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; ld_iq = 1'b0; cw_i = '0; dq_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count",    wv_t'(count),    wv_t'(0));
    chk("rst_dq_valid", wv_t'(dq_valid), wv_t'(0));
    chk("rst_full",     wv_t'(full),     wv_t'(0));
    chk("rst_ack",      wv_t'(ack_o),    wv_t'(0));
    chk("rst_word",     wv_t'(cw_o),     wv_t'(0));
    rst = 1'b0;

    // First push is visible at the head one cycle later.
    cyc(1'b1, 32'h60, 1'b0, 1'b0);
    chk("first_pc", wv_t'(cw_o.pc), wv_t'(32'h60));
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Fill to full, refused 9th push, then pop at full with ld held.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'(i * 4), 1'b0, 1'b0);
    chk("full_flag", wv_t'(full), wv_t'(1));
    cyc(1'b1, 32'h99, 1'b0, 1'b0);
    chk("full_hold_count", wv_t'(count), wv_t'(DEPTH));
    chk("full_hold_head",  wv_t'(cw_o.pc), wv_t'(32'h0));
    cyc(1'b1, 32'hAA, 1'b1, 1'b0);
    chk("pop_at_full_count", wv_t'(count), wv_t'(DEPTH - 1));
    cyc(1'b1, 32'hAA, 1'b1, 1'b0);
    drain();

    // Simultaneous push and pop at count 3.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h200 + 32'(i * 4), 1'b0, 1'b0);
    cyc(1'b1, 32'h20C, 1'b1, 1'b0);
    chk("pp_count", wv_t'(count), wv_t'(3));
    chk("pp_head",  wv_t'(cw_o.pc), wv_t'(32'h204));
    drain();

    // Pointer wrap under steady push/pop.
    cyc(1'b1, 32'h300, 1'b0, 1'b0);
    cyc(1'b1, 32'h304, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 32'h400 + 32'(i * 4), 1'b1, 1'b0);
      chk("wrap_count_le", wv_t'(count <= CNT_W'(DEPTH)), wv_t'(1));
    end
    drain();

    // Flush at count 5 with a push attempt.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h500 + 32'(i * 4), 1'b0, 1'b0);
    cyc(1'b1, 32'h5FF, 1'b0, 1'b1);
    chk("flush_count",    wv_t'(count),    wv_t'(0));
    chk("flush_dq_valid", wv_t'(dq_valid), wv_t'(0));
    cyc(1'b1, 32'h100, 1'b0, 1'b0);
    chk("post_flush_pc", wv_t'(cw_o.pc), wv_t'(32'h100));
    drain();

    // Mid-operation reset zeroes the head word.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h700 + 32'(i * 4), 1'b0, 1'b0);
    rst = 1'b1; ld_iq = 1'b0; dq_ready = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    mcount = 0;
    chk("mid_rst_count",    wv_t'(count),    wv_t'(0));
    chk("mid_rst_dq_valid", wv_t'(dq_valid), wv_t'(0));
    chk("mid_rst_word",     wv_t'(cw_o),     wv_t'(0));
    cyc(1'b1, 32'h800, 1'b0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Circular FIFO between the instruction register/decode stage and the Tomasulo dispatch logic (reservation-station/ROB allocation).
- Accepts one decoded control word per cycle from the decode stage using the ld_iq/ack_o handshake.
- Presents the oldest entry to dispatch using a valid/ready handshake.
- Supports a single-cycle flush for branch/JALR mispredict recovery.

Parameters:
- DEPTH, 8, number of entries; must be a power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- ld_iq  input  1  decode stage requests to enqueue control_word_i. Held high until acknowledged.
- control_word_i  input  $bits(tomasula_types::ctl_word)  decoded control word (op, src1/src2 reg/data/valid, funct3, funct7, rd, pc).
- ack_o  output  1  enqueue accepted this cycle. The decode stage samples it combinationally.
- dq_valid  output  1  head entry is valid.
- control_word_o  output  $bits(tomasula_types::ctl_word)  head entry (oldest).
- dq_ready  input  1  dispatch consumes the head this cycle.
- flush  input  1  discard all entries.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.

Behaviour:
- State: storage array[DEPTH], head pointer and tail pointer (log2(DEPTH) bits each, natural wrap DEPTH-1 -> 0), count register.
- Reset values:
  - head, tail and count = 0.
  - All storage = 0, so control_word_o = 0 after reset.
  - dq_valid = 0, ack_o = 0, full = 0.
- ack_o = ld_iq & ~full & ~flush (purely combinational).
  - ack_o must not depend on dq_ready, to avoid a comb loop through dispatch.
  - When full, no push is accepted even if a pop happens the same cycle.
- Push (ack_o = 1): storage[tail] <= control_word_i; tail <= tail+1 at the clock edge.
  - Each cycle with ld_iq=1 and ack_o=1 is exactly one push.
  - ld_iq=1 with ack_o=0 leaves all state unchanged; the producer holds its word.
- dq_valid = (count != 0). control_word_o = storage[head], combinational read.
- Pop (dq_valid & dq_ready & ~flush): head <= head+1. dq_ready while empty is ignored.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle (requires 0 < count < DEPTH): unchanged.
- Data is written and read in order. An entry pushed in cycle N is visible at control_word_o in cycle N+1 at the earliest (it is the head when the queue was empty).
- flush (priority over everything):
  - ack_o = 0.
  - Next cycle: head = tail = count = 0 and dq_valid = 0.
  - Storage contents are not cleared.
  - ld_iq during flush is not accepted; the producer retries next cycle.
- rst asserted mid-operation behaves like flush and additionally zeroes storage. Reset overrides flush.
- No other internal FSM. Queue state is fully described by (head, tail, count).
- Assertions (verification only):
  - count <= DEPTH.
  - Push never occurs while full.
  - Pop never occurs while empty.

Decomposition:
- tomasula_types package owns ctl_word and the op enum (ARITH, LUI, AUIPC, BRANCH, LD, ST, JALR); no new typedefs are required.
- The handshake is carried on the existing IQ_2_IR interface: the queue side drives ack_o, the decode side drives ld_iq and control_word.
- Dispatch-side signals are plain ports for now.
- Optional sub-module: iq_ptr, a wrapping pointer register with increment and clear, instantiated twice.

Test Plan:
- Reset, then ld_iq=1 with control_word_i.pc=32'h60 -> ack_o=1 same cycle; next cycle dq_valid=1, control_word_o.pc=32'h60, count=1.
- Push 8 words (pc 0x0..0x1C) with dq_ready=0 -> full=1, count=8; 9th ld_iq gives ack_o=0 and state unchanged. Then dq_ready=1 for 8 cycles -> pcs 0x0..0x1C emerge in order, then dq_valid=0.
- count=3, ld_iq=1 and dq_ready=1 in the same cycle -> count stays 3; head advances by one and tail advances by one.
- count=8 with ld_iq=1 and dq_ready=1 -> pop occurs, ack_o=0, count=7; the next cycle's ld_iq is acked.
- Wrap-around: 20 push/pop pairs with DEPTH=8 -> output order matches input order across pointer wrap; count never exceeds 8.
- count=5, flush=1 with ld_iq=1 -> ack_o=0; next cycle count=0, dq_valid=0. A subsequent push of pc=32'h100 appears at control_word_o one cycle later.
